// File: rtl/count_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : count_scheduler                                          |
// | Description : Round-robin owner of one shared WIDTH-bit up-counter.    |
// |               Grants one requester at a time, counts 0..limit, then    |
// |               pulses done with the finishing requester's index.        |
// | Option      : COUNT_SCHED_ABORT_EN - dropping req during a run ends    |
// |               it early with aborted=1.                                 |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module count_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [NREQ-1:0]                             req_i,
  input  logic [NREQ*WIDTH-1:0]                       limit_i,
  output logic [NREQ-1:0]                             grant_o,
  output logic                                        busy_o,
  output logic [WIDTH-1:0]                            count_o,
  output logic                                        done_o,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0]  done_id_o,
  output logic                                        aborted_o
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [WIDTH-1:0]  lim_q, lim_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic              done_q, done_d;
  logic [IDW-1:0]    done_id_q, done_id_d;
  logic              aborted_q, aborted_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    winner_q, winner_d;

  logic              found;
  logic [IDW-1:0]    win_idx;
  logic [WIDTH-1:0]  win_lim;
  logic [IDW-1:0]    ptr_after_winner;

  // Rotating priority search: first set req bit at or above ptr, wrapping.
  always_comb begin
    int pos;
    pos     = 0;
    found   = 1'b0;
    win_idx = '0;
    win_lim = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = (int'(ptr_q) + k) % NREQ;
      if (!found && req_i[pos]) begin
        found   = 1'b1;
        win_idx = IDW'(pos);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) begin
        win_lim = limit_i[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next rotation start is one past the current owner, modulo NREQ.
  assign ptr_after_winner = (winner_q == IDW'(NREQ - 1)) ? '0 : winner_q + 1'b1;

  // Next-state and datapath control; done/aborted default to a single-cycle pulse.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    lim_d     = lim_q;
    count_d   = count_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    aborted_d = 1'b0;
    ptr_d     = ptr_q;
    winner_d  = winner_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d  = NREQ'(1) << win_idx;
          lim_d    = win_lim;
          count_d  = '0;
          winner_d = win_idx;
          state_d  = RUN;
        end
      end
      RUN: begin
`ifdef COUNT_SCHED_ABORT_EN
        if (!req_i[winner_q]) begin
          // Owner withdrew: finish now, leaving the count where it stopped.
          grant_d   = '0;
          done_d    = 1'b1;
          aborted_d = 1'b1;
          done_id_d = winner_q;
          ptr_d     = ptr_after_winner;
          state_d   = DONE;
        end else
`endif
        if (count_q == lim_q) begin
          grant_d   = '0;
          done_d    = 1'b1;
          done_id_d = winner_q;
          ptr_d     = ptr_after_winner;
          state_d   = DONE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      lim_q     <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      aborted_q <= 1'b0;
      ptr_q     <= '0;
      winner_q  <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      lim_q     <= lim_d;
      count_q   <= count_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      aborted_q <= aborted_d;
      ptr_q     <= ptr_d;
      winner_q  <= winner_d;
    end
  end

  assign grant_o   = grant_q;
  assign busy_o    = (state_q != IDLE);
  assign count_o   = count_q;
  assign done_o    = done_q;
  assign done_id_o = done_id_q;
  assign aborted_o = aborted_q;

endmodule
`default_nettype wire

// File: tb/tb_count_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_count_scheduler                                       |
// | Description : Scoreboard bench for count_scheduler. Stimulus pushes    |
// |               the expected completion record; a monitor pops and       |
// |               compares on every done pulse.                            |
// | Option      : COUNT_SCHED_ABORT_EN selects the abort expectation.      |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_count_scheduler;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] limit;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic [WIDTH-1:0]      count;
  logic                  done;
  logic [1:0]            done_id;
  logic                  aborted;

  typedef struct packed {
    logic [1:0] id;
    logic       ab;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_err;

  count_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req),
    .limit_i   (limit),
    .grant_o   (grant),
    .busy_o    (busy),
    .count_o   (count),
    .done_o    (done),
    .done_id_o (done_id),
    .aborted_o (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every done pulse must match the oldest expected record.
  always @(posedge clk) begin
    #1;
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_id", 32'(done_id), 32'(e.id));
        chk("aborted", 32'(aborted), 32'(e.ab));
        chk("done count", 32'(count), 32'(e.cnt));
        chk("done grant", 32'(grant), 32'd0);
        chk("done busy", 32'(busy), 32'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    req   = '0;
    limit = '0;
    tick();
    tick();
    chk("reset grant", 32'(grant), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset count", 32'(count), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset done_id", 32'(done_id), 32'd0);
    chk("reset aborted", 32'(aborted), 32'd0);
    reset = 1'b0;
    tick();

    // Single request, limit 3.
    req = 4'b0001;
    limit[0*WIDTH +: WIDTH] = 8'd3;
    exp_q.push_back('{id: 2'd0, ab: 1'b0, cnt: 8'd3});
    tick();
    chk("t1 grant", 32'(grant), 32'b0001);
    chk("t1 busy", 32'(busy), 32'd1);
    chk("t1 count0", 32'(count), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t1 count step", 32'(count), 32'(k));
    end
    tick();
    chk("t1 done", 32'(done), 32'd1);
    req = '0;
    tick();
    chk("t1 idle busy", 32'(busy), 32'd0);
    chk("t1 done cleared", 32'(done), 32'd0);

    // Zero limit on requester 2.
    req = 4'b0100;
    limit[2*WIDTH +: WIDTH] = 8'd0;
    exp_q.push_back('{id: 2'd2, ab: 1'b0, cnt: 8'd0});
    tick();
    chk("t2 grant", 32'(grant), 32'b0100);
    chk("t2 count", 32'(count), 32'd0);
    tick();
    chk("t2 done", 32'(done), 32'd1);
    req = '0;
    tick();
    chk("t2 idle", 32'(busy), 32'd0);

    // Reset in the middle of a run at count 5.
    req = 4'b0010;
    limit[1*WIDTH +: WIDTH] = 8'd9;
    tick();
    chk("t5 grant", 32'(grant), 32'b0010);
    for (int k = 0; k < 5; k++) tick();
    chk("t5 count5", 32'(count), 32'd5);
    reset = 1'b1;
    tick();
    chk("t5 grant", 32'(grant), 32'd0);
    chk("t5 count", 32'(count), 32'd0);
    chk("t5 busy", 32'(busy), 32'd0);
    chk("t5 done", 32'(done), 32'd0);
    reset = 1'b0;
    req   = '0;
    tick();

    // Round robin, all requesters held, all limits 1; rotation restarts at 0.
    for (int i = 0; i < NREQ; i++) limit[i*WIDTH +: WIDTH] = 8'd1;
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      exp_q.push_back('{id: 2'(r % 4), ab: 1'b0, cnt: 8'd1});
      tick();
      chk("rr grant", 32'(grant), 32'(1 << (r % 4)));
      tick();
      tick();
      chk("rr done", 32'(done), 32'd1);
      if (r == 4) req = '0;
      tick();
    end
    tick();
    chk("rr idle", 32'(busy), 32'd0);

    // Maximum limit on requester 1: no wrap, done after 256 RUN cycles.
    req = 4'b0010;
    limit[1*WIDTH +: WIDTH] = 8'd255;
    exp_q.push_back('{id: 2'd1, ab: 1'b0, cnt: 8'd255});
    tick();
    chk("max grant", 32'(grant), 32'b0010);
    for (int k = 0; k < 128; k++) tick();
    chk("max count128", 32'(count), 32'd128);
    for (int k = 0; k < 127; k++) tick();
    chk("max count255", 32'(count), 32'd255);
    chk("max not done yet", 32'(done), 32'd0);
    tick();
    chk("max done", 32'(done), 32'd1);
    req = '0;
    tick();
    tick();
    chk("max idle", 32'(busy), 32'd0);

    // Requester 0 drops req at count 2 with limit 9.
    req = 4'b0001;
    limit[0*WIDTH +: WIDTH] = 8'd9;
`ifdef COUNT_SCHED_ABORT_EN
    exp_q.push_back('{id: 2'd0, ab: 1'b1, cnt: 8'd2});
`else
    exp_q.push_back('{id: 2'd0, ab: 1'b0, cnt: 8'd9});
`endif
    tick();
    chk("ab grant", 32'(grant), 32'b0001);
    tick();
    tick();
    chk("ab count2", 32'(count), 32'd2);
    req  = '0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("ab done seen", 32'(seen), 32'd1);
    tick();
    chk("ab idle", 32'(busy), 32'd0);
    tick();
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
